// File: rtl/packet_pacer.sv
// Dual-channel token-bucket pacer: turns a byte rate and packet length into
// per-packet start grants for two generators and counts throttled cycles.
module packet_pacer #(
  parameter int unsigned CLK_MHZ         = 322,
  parameter int unsigned BYTES_PER_CYCLE = 64,
  parameter int unsigned BUCKET_MAX_USEC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic [31:0] BYTES_PER_USEC,
  input  logic [7:0]  CYCLES_PER_PACKET,
  input  logic        req1,
  input  logic        req2,
  output logic        grant1,
  output logic        grant2,
  output logic        busy,
  output logic [31:0] stall1,
  output logic [31:0] stall2
);

  localparam int unsigned RATE_W  = 32;
  localparam int unsigned COST_W  = 14;
  localparam int unsigned BKT_W   = 40;
  localparam int unsigned SUM_W   = BKT_W + 1;
  localparam int unsigned STALL_W = 32;
  localparam int unsigned TMR_W   = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLK_MHZ - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [RATE_W-1:0]    rate_q, rate_d;
  logic [COST_W-1:0]    cost_q, cost_d;
  logic [BKT_W-1:0]     bkt_q [2];
  logic [BKT_W-1:0]     bkt_d [2];
  logic [1:0]           grant_q, grant_d;
  logic [STALL_W-1:0]   stall_q [2];
  logic [STALL_W-1:0]   stall_d [2];

  logic                 run_c, tick_c;
  logic [1:0]           req_c, elig_c;
  logic [COST_W-1:0]    cost_new_c;
  logic [BKT_W-1:0]     cost_ext_c, rate_cap_c, cap_c;
  logic [SUM_W-1:0]     sum_c  [2];
  logic [BKT_W-1:0]     clip_c [2];

  assign run_c      = (state_q == ST_RUN);
  assign tick_c     = run_c && (timer_q == TMR_LAST);
  assign req_c      = {req2, req1};
  assign cost_new_c = COST_W'(32'(CYCLES_PER_PACKET) * BYTES_PER_CYCLE);
  assign cost_ext_c = BKT_W'(cost_q);
  assign rate_cap_c = BKT_W'(rate_q) * BKT_W'(BUCKET_MAX_USEC);
  // Bucket ceiling must hold at least one packet so a low rate can still grant.
  assign cap_c      = (rate_cap_c > cost_ext_c) ? rate_cap_c : cost_ext_c;

  // Eligibility uses the registered bucket; credit is added then clipped to cap.
  always_comb begin
    elig_c = '0;
    for (int c = 0; c < 2; c++) begin
      elig_c[c] = run_c && req_c[c] && !grant_q[c] &&
                  ((rate_q == '0) || (bkt_q[c] >= cost_ext_c));
      sum_c[c]  = SUM_W'(bkt_q[c]) + (tick_c ? SUM_W'(rate_q) : '0);
      clip_c[c] = (sum_c[c] > SUM_W'(cap_c)) ? cap_c : sum_c[c][BKT_W-1:0];
    end
  end

  // Next-state: halt beats start; start (re)loads config from any state.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rate_d  = rate_q;
    cost_d  = cost_q;
    grant_d = '0;
    for (int c = 0; c < 2; c++) begin
      bkt_d[c]   = bkt_q[c];
      stall_d[c] = stall_q[c];
      if (run_c && req_c[c] && !grant_q[c] && (stall_q[c] != '1))
        stall_d[c] = stall_q[c] + STALL_W'(1);
    end

    if (halt) begin
      state_d = ST_IDLE;
      timer_d = '0;
      for (int c = 0; c < 2; c++) bkt_d[c] = '0;
    end else if (start) begin
      state_d = ST_RUN;
      rate_d  = BYTES_PER_USEC;
      cost_d  = cost_new_c;
      timer_d = '0;
      for (int c = 0; c < 2; c++) begin
        bkt_d[c]   = BKT_W'(cost_new_c);
        stall_d[c] = '0;
      end
    end else if (state_q == ST_RUN) begin
      timer_d = tick_c ? '0 : timer_q + TMR_W'(1);
      for (int c = 0; c < 2; c++) begin
        grant_d[c] = elig_c[c];
        bkt_d[c]   = clip_c[c] - ((elig_c[c] && (rate_q != '0)) ? cost_ext_c : '0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      rate_q  <= '0;
      cost_q  <= '0;
      grant_q <= '0;
      for (int c = 0; c < 2; c++) begin
        bkt_q[c]   <= '0;
        stall_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rate_q  <= rate_d;
      cost_q  <= cost_d;
      grant_q <= grant_d;
      for (int c = 0; c < 2; c++) begin
        bkt_q[c]   <= bkt_d[c];
        stall_q[c] <= stall_d[c];
      end
    end
  end

  assign grant1 = grant_q[0];
  assign grant2 = grant_q[1];
  assign busy   = run_c;
  assign stall1 = stall_q[0];
  assign stall2 = stall_q[1];

endmodule

// File: tb/tb_packet_pacer.sv
// Bench for packet_pacer: token-bucket reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized runs.
module tb_packet_pacer;

  localparam int unsigned CLK_MHZ = 10;
  localparam int unsigned BPC     = 64;
  localparam int unsigned BMU     = 4;
  localparam longint      SAT     = 64'h0000_0000_FFFF_FFFF;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halt  = 1'b0;
  logic        req1  = 1'b0;
  logic        req2  = 1'b0;
  logic [31:0] bpu   = 32'd0;
  logic [7:0]  cpp   = 8'd0;
  logic        grant1, grant2, busy;
  logic [31:0] stall1, stall2;

  packet_pacer #(
    .CLK_MHZ(CLK_MHZ), .BYTES_PER_CYCLE(BPC), .BUCKET_MAX_USEC(BMU)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .BYTES_PER_USEC(bpu), .CYCLES_PER_PACKET(cpp),
    .req1(req1), .req2(req2), .grant1(grant1), .grant2(grant2),
    .busy(busy), .stall1(stall1), .stall2(stall2)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer token buckets.
  bit     m_run;
  int     m_timer;
  longint m_rate, m_cost;
  longint m_bkt   [2];
  bit     m_grant [2];
  longint m_stall [2];

  function automatic bit m_req(int c);
    return (c == 0) ? req1 : req2;
  endfunction

  function automatic bit f_elig(int c);
    return m_run && m_req(c) && !m_grant[c] && (m_rate == 0 || m_bkt[c] >= m_cost);
  endfunction

  function automatic longint f_bkt(int c);
    longint cap, nb;
    cap = m_rate * BMU;
    if (cap < m_cost) cap = m_cost;
    nb = m_bkt[c] + ((m_run && m_timer == int'(CLK_MHZ) - 1) ? m_rate : 0);
    if (nb > cap) nb = cap;
    if (f_elig(c) && m_rate != 0) nb = nb - m_cost;
    return nb;
  endfunction

  function automatic longint f_stall(int c);
    if (m_run && m_req(c) && !m_grant[c] && m_stall[c] < SAT) return m_stall[c] + 1;
    return m_stall[c];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run <= 1'b0; m_timer <= 0; m_rate <= 0; m_cost <= 0;
      for (int c = 0; c < 2; c++) begin
        m_bkt[c] <= 0; m_grant[c] <= 1'b0; m_stall[c] <= 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) m_stall[c] <= f_stall(c);
      if (halt) begin
        m_run <= 1'b0; m_timer <= 0;
        for (int c = 0; c < 2; c++) begin m_bkt[c] <= 0; m_grant[c] <= 1'b0; end
      end else if (start) begin
        m_run <= 1'b1; m_timer <= 0;
        m_rate <= longint'(bpu);
        m_cost <= longint'(cpp) * BPC;
        for (int c = 0; c < 2; c++) begin
          m_bkt[c] <= longint'(cpp) * BPC; m_grant[c] <= 1'b0; m_stall[c] <= 0;
        end
      end else if (m_run) begin
        m_timer <= (m_timer + 1) % int'(CLK_MHZ);
        for (int c = 0; c < 2; c++) begin
          m_grant[c] <= f_elig(c);
          m_bkt[c]   <= f_bkt(c);
        end
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int g1_t[$];
  int g2_t[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic compare_all();
    chk("grant1", longint'(grant1), longint'(m_grant[0]));
    chk("grant2", longint'(grant2), longint'(m_grant[1]));
    chk("busy",   longint'(busy),   longint'(m_run));
    chk("stall1", longint'(stall1), m_stall[0]);
    chk("stall2", longint'(stall2), m_stall[1]);
  endtask

  // One clock: compare on the falling edge, then return just after the rising edge.
  task automatic step();
    @(negedge clk);
    compare_all();
    if (grant1) g1_t.push_back(cyc);
    if (grant2) g2_t.push_back(cyc);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] rate, input logic [7:0] pkt);
    bpu   = rate;
    cpp   = pkt;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic longint gap1(int a, int b);
    if (b < g1_t.size()) return longint'(g1_t[b] - g1_t[a]);
    return -1;
  endfunction

  function automatic logic [31:0] pick_rate();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd512;
      2:       return 32'd1024;
      3:       return 32'd2048;
      4:       return 32'($urandom_range(1, 4096));
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic rand_run(input int ncyc);
    int r;
    for (int i = 0; i < ncyc; i++) begin
      r     = int'($urandom_range(0, 999));
      start = 1'b0;
      halt  = 1'b0;
      if (r < 3) begin
        start = 1'b1; bpu = pick_rate(); cpp = 8'($urandom_range(1, 32));
      end else if (r < 5) halt = 1'b1;
      else if (r == 5) begin start = 1'b1; halt = 1'b1; end
      else if (r < 30) bpu = pick_rate();
      if (m_grant[0]) req1 = 1'b0; else if (!req1 && $urandom_range(0, 3) == 0) req1 = 1'b1;
      if (m_grant[1]) req2 = 1'b0; else if (!req2 && $urandom_range(0, 2) == 0) req2 = 1'b1;
      step();
    end
    start = 1'b0;
    halt  = 1'b0;
  endtask

  initial begin
    int k0, n0, n2;
    @(posedge clk); #1;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_grant1", longint'(grant1), 0);
    chk("rst_grant2", longint'(grant2), 0);
    chk("rst_busy",   longint'(busy),   0);
    chk("rst_stall1", longint'(stall1), 0);
    chk("rst_stall2", longint'(stall2), 0);

    // Unlimited rate: grant every other cycle, no second channel activity.
    pulse_start(32'd0, 8'd16);
    n0 = g1_t.size(); n2 = g2_t.size();
    req1 = 1'b1;
    repeat (20) step();
    req1 = 1'b0;
    step();
    chk("unl_grants",  longint'(g1_t.size() - n0), 10);
    chk("unl_spacing", gap1(n0, n0 + 1), 2);
    chk("unl_stall1",  longint'(stall1), 10);
    chk("unl_grant2",  longint'(g2_t.size() - n2), 0);
    halt = 1'b1; step(); halt = 1'b0;
    chk("halt_busy0", longint'(busy), 0);

    // Paced at one packet per microsecond.
    pulse_start(32'd1024, 8'd16);
    k0 = cyc; n0 = g1_t.size();
    req1 = 1'b1;
    repeat (40) step();
    chk("paced_first", (n0 < g1_t.size()) ? longint'(g1_t[n0] - k0) : -1, 1);
    chk("paced_gap1",  gap1(n0, n0 + 1), 10);
    chk("paced_gap2",  gap1(n0 + 1, n0 + 2), 10);
    chk("paced_count", longint'(g1_t.size() - n0), 4);

    // Halt freezes stalls and stops grants.
    halt = 1'b1; step(); halt = 1'b0;
    n0 = g1_t.size();
    repeat (5) step();
    chk("halt_busy",    longint'(busy), 0);
    chk("halt_stall1",  longint'(stall1), 37);
    chk("halt_nogrant", longint'(g1_t.size() - n0), 0);
    req1 = 1'b0;

    // Start and halt together: halt wins.
    start = 1'b1; halt = 1'b1; step(); start = 1'b0; halt = 1'b0;
    step();
    chk("sh_busy", longint'(busy), 0);

    // Restart with a burst-capable rate, stalls cleared.
    pulse_start(32'd2048, 8'd16);
    chk("restart_busy",   longint'(busy), 1);
    chk("restart_stall1", longint'(stall1), 0);
    repeat (200) step();
    n0 = g1_t.size();
    req1 = 1'b1;
    repeat (16) step();
    chk("burst_count", longint'(g1_t.size() - n0), 8);
    chk("burst_span",  gap1(n0, n0 + 7), 14);

    // Asynchronous reset between edges.
    repeat (7) step();
    #2 reset = 1'b1;
    #1;
    chk("arst_grant1", longint'(grant1), 0);
    chk("arst_busy",   longint'(busy), 0);
    chk("arst_stall1", longint'(stall1), 0);
    step();
    reset = 1'b0;
    n0 = g1_t.size();
    repeat (10) step();
    chk("arst_nogrant", longint'(g1_t.size() - n0), 0);
    chk("arst_idle",    longint'(busy), 0);
    req1 = 1'b0;

    // Randomized runs against the model.
    for (int run = 0; run < 25; run++) begin
      pulse_start(pick_rate(), 8'($urandom_range(1, 32)));
      rand_run(600);
    end
    halt = 1'b1; step(); halt = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
